// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido pipeline front end.
// Holds the word/address width used by memory, programcounter and the
// boot loader, the default load-terminating sentinel, and the boot
// sequencer state encoding.
package lapido_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] END_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_CLEAR,
    ST_RUN,
    ST_ERROR
  } boot_state_e;

  // Write-side view of the instruction memory port.
  typedef struct packed {
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] data;
    logic              cs;
    logic              we;
    logic              oe;
  } mem_port_t;

endpackage

// File: rtl/boot_clear_timer.sv
// Register-file clear countdown for the boot sequencer.
// Ports:
//   clock, reset : system clock, async active-high reset
//   load         : load the counter with CYCLES
//   dec          : decrement this cycle (held high while clearing)
//   expire       : high in the last clear cycle (counter == 1 while dec)
module boot_clear_timer #(
  parameter int CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= CW'(CYCLES);
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  // Expiring on the value 1 (not 0) gives exactly CYCLES clear cycles
  // counting the one that starts with the freshly loaded value.
  assign expire = dec && (cnt == CW'(1));

endmodule

// File: rtl/boot_loader.sv
// Boot sequencer ahead of instruction fetch.
// Streams program words from the BIOS source (valid/ready) into
// instruction memory starting at address 0, holds the register file in
// reset for CLEAR_CYCLES cycles, then hands memory addressing to the PC.
// Ports:
//   clock, reset          : system clock, async active-high reset
//   start                 : begin loading (only looked at in IDLE)
//   in_data/in_valid/in_ready : program word stream
//   pc_address            : PC value, drives mem_address in RUN
//   mem_*                 : instruction memory port (cs active-low)
//   word_count            : words written so far
//   on_bios               : low only in RUN
//   reg_file_reset        : register-file reset request during CLEAR
//   enable_pc, done       : high in RUN
//   error                 : overflow, sticky until reset
module boot_loader
  import lapido_pkg::*;
#(
  parameter int                MAX_WORDS    = 256,
  parameter logic [WORD_W-1:0] END_WORD     = END_WORD_DEF,
  parameter int                CLEAR_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] pc_address,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [WORD_W-1:0] word_count,
  output logic              on_bios,
  output logic              reg_file_reset,
  output logic              enable_pc,
  output logic              done,
  output logic              error
);

  localparam logic [WORD_W-1:0] MAX_W = WORD_W'(MAX_WORDS);

  boot_state_e state, state_nxt;

  logic [WORD_W-1:0] addr_q, data_q, count_q;
  logic              accept, is_end, full, clear_done;
  mem_port_t         mem;

  // in_ready is purely state==LOAD, so a handshake is in_valid in LOAD.
  assign accept = (state == ST_LOAD) && in_valid;
  assign is_end = (in_data == END_WORD);
  assign full   = (count_q == MAX_W);

  // ---- state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---- next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (is_end)    state_nxt = ST_CLEAR;
          else if (full) state_nxt = ST_ERROR;
          else           state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: state_nxt = ST_LOAD;
      ST_CLEAR: if (clear_done) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---- datapath: captured write address/data and word counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept && !is_end && !full) begin
        addr_q <= count_q;
        data_q <= in_data;
      end
      // Count only completes at the end of WRITE, so a reset mid-write
      // leaves the word uncounted. Saturates at MAX_WORDS.
      if (state == ST_WRITE && count_q != MAX_W)
        count_q <= count_q + 1'b1;
    end
  end

  boot_clear_timer #(
    .CYCLES (CLEAR_CYCLES)
  ) u_clear (
    .clock  (clock),
    .reset  (reset),
    .load   (accept && is_end),
    .dec    (state == ST_CLEAR),
    .expire (clear_done)
  );

  // ---- outputs
  always_comb begin
    mem            = '{address: addr_q, data: data_q, cs: 1'b1, we: 1'b0, oe: 1'b0};
    in_ready       = 1'b0;
    on_bios        = 1'b1;
    reg_file_reset = 1'b0;
    enable_pc      = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      ST_LOAD:  in_ready = 1'b1;
      ST_WRITE: begin
        mem.cs = 1'b0;
        mem.we = 1'b1;
      end
      ST_CLEAR: reg_file_reset = 1'b1;
      ST_RUN: begin
        mem.address = pc_address;
        mem.cs      = 1'b0;
        mem.oe      = 1'b1;
        enable_pc   = 1'b1;
        done        = 1'b1;
        on_bios     = 1'b0;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign mem_address = mem.address;
  assign mem_data    = mem.data;
  assign mem_cs      = mem.cs;
  assign mem_we      = mem.we;
  assign mem_oe      = mem.oe;
  assign word_count  = count_q;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int          MAXW  = 4;
  localparam int          CLRC  = 4;
  localparam logic [31:0] ENDW  = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_address = '0;
  logic [31:0] mem_address, mem_data, word_count;
  logic        mem_cs, mem_we, mem_oe, on_bios, reg_file_reset, enable_pc, done, error;

  boot_loader #(.MAX_WORDS(MAXW), .END_WORD(ENDW), .CLEAR_CYCLES(CLRC)) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .pc_address(pc_address),
    .mem_address(mem_address), .mem_data(mem_data), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_oe(mem_oe), .word_count(word_count),
    .on_bios(on_bios), .reg_file_reset(reg_file_reset),
    .enable_pc(enable_pc), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observed memory writes, one entry per cycle with mem_we high.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          rfr_cnt = 0;
  int          bad_we = 0;
  logic [31:0] tx_q[$];

  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_data);
      if (mem_cs !== 1'b0 || mem_oe !== 1'b0 || in_ready !== 1'b0) bad_we++;
    end
    if (reg_file_reset) rfr_cnt++;
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    wr_addr.delete(); wr_data.delete();
    rfr_cnt = 0; bad_we = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present tx_q words in order; a word advances only on a handshake.
  task automatic stream(input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < tx_q.size() && cyc < 400) begin
      @(negedge clock);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = tx_q[idx];
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    chk("stream_accepted", idx, tx_q.size());
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = $urandom;
    repeat (CLRC + 4) @(negedge clock);
  endtask

  // Reference: words before the sentinel land at 0,1,2...; one word past
  // capacity without a sentinel means overflow.
  task automatic check_outcome(input string tag);
    logic [31:0] exp_w[$];
    bit          saw_end = 0;
    bit          ovf = 0;
    bit          ok;
    foreach (tx_q[i]) begin
      if (saw_end || ovf) break;
      if (tx_q[i] == ENDW) saw_end = 1;
      else if (exp_w.size() == MAXW) ovf = 1;
      else exp_w.push_back(tx_q[i]);
    end
    ok = saw_end && !ovf;
    chk({tag, "_nwrites"}, wr_addr.size(), exp_w.size());
    foreach (exp_w[i]) begin
      if (i < wr_addr.size()) begin
        chk({tag, "_addr"}, wr_addr[i], i);
        chk({tag, "_data"}, wr_data[i], exp_w[i]);
      end
    end
    chk({tag, "_count"}, word_count, exp_w.size());
    chk({tag, "_done"}, done, ok);
    chk({tag, "_enpc"}, enable_pc, ok);
    chk({tag, "_error"}, error, ovf);
    chk({tag, "_onbios"}, on_bios, !ok);
    chk({tag, "_rfr_cycles"}, rfr_cnt, ok ? CLRC : 0);
    chk({tag, "_cs"}, mem_cs, !ok);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we_side"}, bad_we, 0);
  endtask

  initial begin
    // ---- reset values, and in_valid ignored in IDLE
    #2;
    chk("rst_ready", in_ready, 0);
    chk("rst_cs", mem_cs, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_onbios", on_bios, 1);
    do_reset();
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_flags", {reg_file_reset, enable_pc, done, error, mem_oe}, 0);
    in_valid = 1'b1; in_data = 32'h1234;
    repeat (3) @(negedge clock);
    chk("idle_ready", in_ready, 0);
    chk("idle_nowrite", wr_addr.size(), 0);
    in_valid = 1'b0;

    // ---- directed three words + sentinel, then PC sweep in RUN
    do_reset(); pulse_start();
    tx_q = '{32'hA1, 32'hA2, 32'hA3, ENDW};
    stream(0);
    check_outcome("basic");
    for (int p = 0; p < 8; p++) begin
      @(posedge clock); #2;
      pc_address = p;
      #1;
      chk("run_addr", mem_address, p);
      chk("run_we", mem_we, 0);
    end

    // ---- capacity boundaries
    do_reset(); pulse_start();
    tx_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    stream(1);
    check_outcome("ovf");
    do_reset(); pulse_start();
    tx_q = '{32'h11, 32'h22, 32'h33, 32'h44, ENDW};
    stream(1);
    check_outcome("full");

    // ---- random lengths (0..5 words), random gaps
    for (int t = 0; t < 8; t++) begin
      int len;
      do_reset(); pulse_start();
      len = $urandom_range(0, MAXW + 1);
      tx_q.delete();
      for (int i = 0; i < len; i++) tx_q.push_back($urandom_range(0, 32'hFFFF_FFFE));
      if (len <= MAXW) tx_q.push_back(ENDW);
      stream(1);
      check_outcome("rand");
    end

    // ---- reset during the write of word 2, then restart
    begin
      int idx = 0;
      bit found = 0;
      do_reset(); pulse_start();
      tx_q = '{32'hB1, 32'hB2, 32'hB3, ENDW};
      for (int c = 0; c < 60; c++) begin
        @(negedge clock);
        if (mem_we && mem_address == 1) begin found = 1; break; end
        in_valid = 1'b1;
        in_data  = tx_q[idx];
        if (in_ready) idx++;
      end
      chk("midw_found", found, 1);
      #2 reset = 1'b1;
      #1;
      chk("midw_we", mem_we, 0);
      chk("midw_count", word_count, 0);
      chk("midw_cs", mem_cs, 1);
      chk("midw_ready", in_ready, 0);
      in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      wr_addr.delete(); wr_data.delete(); rfr_cnt = 0; bad_we = 0;
      pulse_start();
      tx_q = '{32'hC1, ENDW};
      stream(0);
      check_outcome("restart");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
